// File: rtl/qnt_pkg.sv
// Shared types and defaults for the quantum preemption timer.
// Optional feature macro used by the timer: QNT_PRESCALE_EN.
package qnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PEND  = 2'd2
  } qnt_state_t;

  localparam int unsigned QNT_CNT_W           = 32;
  localparam int unsigned QNT_DEFAULT_QUANTUM = 1000;
  localparam int unsigned QNT_PRESCALE        = 16;

endpackage

// File: rtl/qnt_prescaler.sv
// Divides the processor clock into count ticks for the quantum timer.
// Only instantiated when QNT_PRESCALE_EN is defined.
module qnt_prescaler
  import qnt_pkg::*;
#(
  parameter int unsigned PRESCALE = QNT_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_div;
  logic          w_wrap;

  assign w_wrap = (r_div == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (clear) begin
      r_div <= '0;
    end else if (enable) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
    end
  end

  // Tick on the last cycle of each period; halted cycles do not advance it.
  assign tick = enable && w_wrap;

endmodule

// File: rtl/quantum_preempt_timer.sv
// CPU-programmable time-slice timer raising a registered sigint when the quantum expires.
// Define QNT_PRESCALE_EN to count in PRESCALE-cycle ticks instead of raw cycles.
module quantum_preempt_timer
  import qnt_pkg::*;
#(
  parameter int unsigned       CNT_W           = QNT_CNT_W,
  parameter logic [CNT_W-1:0]  DEFAULT_QUANTUM = CNT_W'(QNT_DEFAULT_QUANTUM),
  parameter int unsigned       PRESCALE        = QNT_PRESCALE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stop,
  input  logic             halt,
  input  logic             ack,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             sigint,
  output logic [CNT_W-1:0] count,
  output logic             running
);

  qnt_state_t       r_state;
  qnt_state_t       w_state_next;
  logic [CNT_W-1:0] r_quantum;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_quantum_eff;
  logic             r_sigint;
  logic             w_tick;
  logic             w_start;
  logic             w_expire;

  // A same-edge quantum write is already visible to the IDLE->COUNT reload.
  assign w_quantum_eff = cfg_we ? cfg_data : r_quantum;
  assign w_start       = (r_state == IDLE) && (w_state_next == COUNT);
  assign w_expire      = !stop && !halt && w_tick && (r_count == CNT_W'(1));

`ifdef QNT_PRESCALE_EN
  logic w_psc_en;

  assign w_psc_en = (r_state == COUNT) && !halt;

  qnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_start),
    .enable (w_psc_en),
    .tick   (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!stop && (w_quantum_eff != '0)) w_state_next = COUNT;
      COUNT: begin
        if (stop)          w_state_next = IDLE;
        else if (w_expire) w_state_next = PEND;
      end
      PEND:    if (ack || stop) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    running = (r_state == COUNT);
    sigint  = r_sigint;
    count   = r_count;
  end

  // Stop wins over tick and expiry; the counter saturates at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_quantum <= DEFAULT_QUANTUM;
      r_count   <= '0;
      r_sigint  <= 1'b0;
    end else begin
      if (cfg_we) r_quantum <= cfg_data;
      r_sigint <= (w_state_next == PEND);
      case (r_state)
        IDLE: begin
          if (w_start) r_count <= w_quantum_eff;
        end
        COUNT: begin
          if (stop || w_expire)
            r_count <= '0;
          else if (!halt && w_tick && (r_count != '0))
            r_count <= r_count - 1'b1;
        end
        default: r_count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_quantum_preempt_timer.sv
// Scoreboard bench for quantum_preempt_timer: per-edge expectations from a slice-level model.
module tb_quantum_preempt_timer;

`ifdef QNT_PRESCALE_EN
  localparam int unsigned P = 4;
`else
  localparam int unsigned P = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop = 1'b1;
  logic        halt = 1'b0;
  logic        ack = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        sigint;
  logic [31:0] count;
  logic        running;

  always #5 clk = ~clk;

  quantum_preempt_timer #(.PRESCALE(P)) u_dut (
    .clock    (clk),
    .reset    (rst_n),
    .stop     (stop),
    .halt     (halt),
    .ack      (ack),
    .cfg_we   (cfg_we),
    .cfg_data (cfg_data),
    .sigint   (sigint),
    .count    (count),
    .running  (running)
  );

  typedef struct {
    logic        sig;
    logic        run;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Slice-level reference: ticks left in the slice, pending flag, quantum, sub-tick phase.
  int unsigned m_q, m_left, m_psc;
  bit          m_run, m_pend;

  function automatic void m_reset();
    m_q = 1000; m_left = 0; m_psc = 0; m_run = 0; m_pend = 0;
  endfunction

  function automatic void m_edge(bit s, bit h, bit a, bit w, int unsigned d);
    int unsigned qe;
    qe = w ? d : m_q;
    if (m_pend) begin
      if (a || s) m_pend = 0;
    end else if (m_run) begin
      if (s) begin
        m_run = 0; m_left = 0;
      end else if (!h) begin
        if (m_psc == P - 1) begin
          m_psc = 0;
          m_left = m_left - 1;
          if (m_left == 0) begin m_run = 0; m_pend = 1; end
        end else begin
          m_psc = m_psc + 1;
        end
      end
    end else if (!s && qe != 0) begin
      m_run = 1; m_left = qe; m_psc = 0;
    end
    if (w) m_q = d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic drive_and_model(input bit s, input bit h, input bit a, input bit w, input int unsigned d);
    exp_t e;
    stop = s; halt = h; ack = a; cfg_we = w; cfg_data = d;
    m_edge(s, h, a, w, d);
    e.sig = m_pend; e.run = m_run; e.cnt = m_left;
    sb.push_back(e);
    $display("txn stop=%0d halt=%0d ack=%0d we=%0d data=%0d -> exp sig=%0d run=%0d cnt=%0d",
             s, h, a, w, d, e.sig, e.run, e.cnt);
  endtask

  task automatic step(input bit s, input bit h, input bit a, input bit w, input int unsigned d);
    @(negedge clk);
    drive_and_model(s, h, a, w, d);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_sigint(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step(0, 0, 0, 0, 0);
      sample();
      if (sigint) begin n = i; break; end
    end
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    stop = 1; halt = 0; ack = 0; cfg_we = 0;
    rst_n = 0;
    #1;
    chk({tag, "_sigint"}, 32'(sigint), 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_running"}, 32'(running), 0);
    m_reset();
    sb.delete();
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    drive_and_model(1, 0, 0, 0, 0);
  endtask

  // Monitor: one expectation per active edge, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_sigint", 32'(sigint), 32'(e.sig));
        chk("sb_running", 32'(running), 32'(e.run));
        chk("sb_count", count, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    m_reset();
    #12;
    chk("reset_sigint", 32'(sigint), 0);
    chk("reset_count", count, 0);
    chk("reset_running", 32'(running), 0);
    @(negedge clk);
    rst_n = 1;
    drive_and_model(1, 0, 0, 0, 0);

    // Program 5, expiry, hold until ack, one-cycle re-arm.
    step(0, 0, 0, 1, 5);
    wait_sigint(100, n);
    chk("t2_latency", n, 5 * P);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    wait_sigint(100, n);
    chk("t2_rearm", n, 5 * P + 1);
    step(1, 0, 1, 0, 0);

    // Halt for three cycles mid-slice.
    step(0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    wait_sigint(100, n);
    chk("t3_halt_delay", 2 + 3 + n, 5 * P + 3);
    step(1, 0, 0, 0, 0);

    // Stop on the final count cycle suppresses the interrupt.
    step(1, 0, 0, 1, 4);
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    sample();
    chk("t4_no_sigint", 32'(sigint), 0);
    chk("t4_count_zero", count, 0);
    step(0, 0, 0, 0, 0);
    sample();
    chk("t4_reload", count, 4);

    // New quantum mid-slice does not disturb the running slice.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 9);
    wait_sigint(100, n);
    chk("t5_on_schedule", n, 4 * P - 2);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    sample();
    chk("t5_new_quantum", count, 9);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    sample();
    chk("t5_disabled", 32'(running), 0);

    // Prescale-dependent latency.
    step(1, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0);
    wait_sigint(100, n);
    chk("t6_latency", n, 3 * P);

    // Async reset mid-PEND, then mid-count; default quantum restored.
    async_reset("t1_pend");
    step(0, 0, 0, 1, 5);
    repeat (2) step(0, 0, 0, 0, 0);
    async_reset("t1_count");
    step(0, 0, 0, 0, 0);
    sample();
    chk("t1_default_q", count, 1000);
    step(1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) async_reset("rnd_reset");
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 12));
    end

    sample();
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
